// File: rtl/max_pkg.sv
// max_pkg: shared definitions for the running-maximum tracker and the
// combinational compare/select partitions.
//   max_trk_state_t : tracker FSM states (IDLE, ACCUM, HOLD)
//   DEF_WIDTH       : default unsigned data word width
//   DEF_FRAME_LEN   : default maximum words per frame
package max_pkg;

    localparam int unsigned DEF_WIDTH     = 3;
    localparam int unsigned DEF_FRAME_LEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } max_trk_state_t;

endpackage

// File: rtl/max_cmp_sel.sv
// max_cmp_sel: combinational strict-greater compare and select.
//   a, b   : unsigned operands
//   sel_en : allows y to take a; when low y passes b through unchanged
//   gt     : a > b (unsigned, strict)
//   y      : a when sel_en && gt, otherwise b
// Kept as its own module so an approximate netlist can replace it.
module max_cmp_sel
    import max_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel_en,
    output logic             gt,
    output logic [WIDTH-1:0] y
);

    assign gt = (a > b);
    assign y  = (sel_en && gt) ? a : b;

endmodule

// File: rtl/max_stream_tracker.sv
// max_stream_tracker: frame-based running maximum over a valid/ready stream.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : input handshake
//   in_data, in_last             : sample and end-of-frame marker
//   out_valid/out_ready          : result handshake
//   out_max, out_idx, out_count  : max value, first index of max, word count
// A frame closes on in_last or when FRAME_LEN words have been accepted; the
// result is held until taken, during which no input is accepted.
module max_stream_tracker
    import max_pkg::*;
#(
    parameter  int unsigned WIDTH     = DEF_WIDTH,
    parameter  int unsigned FRAME_LEN = DEF_FRAME_LEN,
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_count
);

    localparam logic [IDX_W:0] COUNT_FULL = (IDX_W + 1)'(FRAME_LEN);
    localparam logic [IDX_W:0] COUNT_ONE  = (IDX_W + 1)'(1);

    max_trk_state_t   r_state;
    max_trk_state_t   w_state_next;
    logic             r_ready_en;
    logic [WIDTH-1:0] r_max;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W:0]   r_count;

    logic             w_in_ready;
    logic             w_beat;
    logic             w_gt;
    logic [WIDTH-1:0] w_sel_y;
    logic [IDX_W:0]   w_count_inc;

    // r_ready_en keeps in_ready low for the cycle following a reset edge.
    assign w_in_ready  = r_ready_en && (r_state != HOLD);
    assign w_beat      = in_valid && w_in_ready;
    assign w_count_inc = r_count + COUNT_ONE;

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == HOLD);
    assign out_max   = r_max;
    assign out_idx   = r_idx;
    assign out_count = r_count;

    // y returns the stored max unless the new word is strictly greater, so
    // ties keep both the value and the earlier index.
    max_cmp_sel #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a      (in_data),
        .b      (r_max),
        .sel_en (w_beat && (r_state == ACCUM)),
        .gt     (w_gt),
        .y      (w_sel_y)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_beat) begin
                    w_state_next = (in_last || FRAME_LEN == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_beat && (in_last || w_count_inc == COUNT_FULL)) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max   <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else if (w_beat) begin
            if (r_state == IDLE) begin
                r_max   <= in_data;
                r_idx   <= '0;
                r_count <= COUNT_ONE;
            end else begin
                r_max   <= w_sel_y;
                r_count <= w_count_inc;
                if (w_gt) begin
                    r_idx <= r_count[IDX_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_max_stream_tracker.sv
module tb_max_stream_tracker;

    localparam int unsigned WIDTH     = 3;
    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned IDX_W     = 3;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_last   = 1'b0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W:0]   out_count;

    int checks = 0;
    int errors = 0;

    bit force_ready = 1'b1;
    bit rand_ready  = 1'b0;
    int frames_sent = 0;

    // behavioural model state
    bit m_init     = 1'b0;
    bit m_ready_en = 1'b0;
    bit m_pending  = 1'b0;
    bit m_zero     = 1'b0;
    int m_frame[$];
    int m_max = 0;
    int m_idx = 0;
    int m_cnt = 0;
    int m_taken   = 0;
    int dut_taken = 0;

    max_stream_tracker #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void frame_result(input int q[$], output int mx, output int ix);
        mx = q[0];
        ix = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] > mx) begin
                mx = q[i];
                ix = i;
            end
        end
    endfunction

    // out_ready driver: changes 2 time units after each rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
        end
    end

    // Compare against the model every cycle, then predict the next edge.
    initial begin
        bit exp_ready;
        int mx;
        int ix;
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("in_ready", int'(in_ready), int'(m_ready_en && !m_pending));
                chk("out_valid", int'(out_valid), int'(m_pending));
                if (m_pending || m_zero) begin
                    chk("out_max", int'(out_max), m_max);
                    chk("out_idx", int'(out_idx), m_idx);
                    chk("out_count", int'(out_count), m_cnt);
                end
                if (out_valid && out_ready && !rst) dut_taken++;
            end
            if (rst) begin
                m_init     = 1'b1;
                m_ready_en = 1'b0;
                m_pending  = 1'b0;
                m_zero     = 1'b1;
                m_frame.delete();
                m_max = 0;
                m_idx = 0;
                m_cnt = 0;
            end else if (m_init) begin
                exp_ready = m_ready_en && !m_pending;
                if (in_valid && exp_ready) begin
                    m_zero = 1'b0;
                    m_frame.push_back(int'(in_data));
                    if (in_last || m_frame.size() == FRAME_LEN) begin
                        frame_result(m_frame, mx, ix);
                        m_max     = mx;
                        m_idx     = ix;
                        m_cnt     = m_frame.size();
                        m_pending = 1'b1;
                        m_frame.delete();
                    end
                end else if (m_pending && out_ready) begin
                    m_pending = 1'b0;
                    m_taken++;
                end
                m_ready_en = 1'b1;
            end
        end
    end

    task automatic send_word(input int d, input bit last);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        in_last  = last;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL in_accept_timeout actual=no_accept expected=accept at %0t", $time);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int w[$], input bit use_last, input bit gaps);
        for (int i = 0; i < w.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_word(w[i], use_last && (i == w.size() - 1));
        end
    endtask

    // Result must be valid in the cycle right after the closing beat.
    task automatic check_result(input string name, input int mx, input int ix, input int ct);
        @(negedge clk);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_max"}, int'(out_max), mx);
        chk({name, "_idx"}, int'(out_idx), ix);
        chk({name, "_count"}, int'(out_count), ct);
        chk({name, "_model_max"}, m_max, mx);
        chk({name, "_model_idx"}, m_idx, ix);
        chk({name, "_model_count"}, m_cnt, ct);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w[$];
        int len;
        bit lst;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_max", int'(out_max), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_count", int'(out_count), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // full frame closed by count
        w = '{2, 5, 3, 5, 1, 7, 0, 4};
        send_frame(w, 1'b0, 1'b0);
        frames_sent++;
        check_result("full", 7, 5, 8);

        // ties keep the first index
        w = '{4, 4, 4};
        send_frame(w, 1'b1, 1'b0);
        frames_sent++;
        check_result("tie", 4, 0, 3);

        // single word frame
        w = '{6};
        send_frame(w, 1'b1, 1'b0);
        frames_sent++;
        check_result("single", 6, 0, 1);

        // back-pressure on the result while upstream keeps offering a word
        force_ready = 1'b0;
        w = '{1, 3};
        send_frame(w, 1'b1, 1'b0);
        frames_sent++;
        in_valid = 1'b1;
        in_data  = 3'd2;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_max", int'(out_max), 3);
            chk("bp_idx", int'(out_idx), 1);
            chk("bp_count", int'(out_count), 2);
            @(posedge clk);
            #1;
        end
        force_ready = 1'b1;
        @(negedge clk);
        chk("bp_take_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_next_in_ready", int'(in_ready), 1);
        chk("bp_next_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        frames_sent++;
        check_result("bp_next", 2, 0, 1);

        // reset aborts an open frame
        w = '{0, 1, 2};
        send_frame(w, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_max", int'(out_max), 0);
        chk("abort_idx", int'(out_idx), 0);
        chk("abort_count", int'(out_count), 0);
        @(posedge clk);
        #1;
        w = '{5};
        send_frame(w, 1'b1, 1'b0);
        frames_sent++;
        check_result("after_abort", 5, 0, 1);

        // randomized traffic with throttling on both sides
        rand_ready = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, FRAME_LEN);
            lst = (len < FRAME_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
            w.delete();
            for (int i = 0; i < len; i++) w.push_back($urandom_range(0, 7));
            send_frame(w, lst, 1'b1);
            frames_sent++;
        end
        rand_ready  = 1'b0;
        force_ready = 1'b1;
        for (int n = 0; n < 50 && (out_valid || m_pending); n++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("frames_model", m_taken, frames_sent);
        chk("frames_dut", dut_taken, frames_sent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
